// File: rtl/grasshopper_decrypt.sv
// Iterative Kuznyechik (GOST R 34.12-2015) single-block decryptor.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     ciphertext handshake, in_data[127:120] = byte a15
//   out_valid/out_ready   plaintext handshake, out_data held until next result
//   key_idx_o/key_i       round-key lookup (1..10, 0 when unused), same-cycle data
//   busy                  high whenever the unit is not idle
module grasshopper_decrypt #(
    parameter int BLOCK_W = 128,
    parameter int ROUNDS  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic [3:0]         key_idx_o,
    input  logic [BLOCK_W-1:0] key_i,
    output logic               busy
);

    // Forward pi substitution; entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] PI = {
        128'hFCEEDD11_CF6E3116_FBC4FADA_23C5044D,
        128'hE977F0DB_932E99BA_1736F1BB_14CD5FC1,
        128'hF918655A_E25CEF21_811C3C42_8B018E4F,
        128'h058402AE_E36A8FA0_060BED98_7FD4D31F,
        128'hEB342C51_EAC848AB_F22A68A2_FD3ACECC,
        128'hB5700E56_080C7612_BF721347_9CB75D87,
        128'h15A19629_107B9AC7_F391786F_9D9EB2B1,
        128'h3275193D_FF358A7E_6D54C680_C3BD0D57,
        128'hDFF524A9_3EA843C9_D779D6F6_7C22B903,
        128'hE00FECDE_7A94B0BC_DCE82850_4E330A4A,
        128'hA7976073_1E006244_1AB83882_649F2641,
        128'hAD454692_275E552F_8CA3A57D_69D5953B,
        128'h0758B340_86AC1DF7_30376BE4_88D9E789,
        128'hE11B8349_4C3FF8FE_8D53AA90_CAD88561,
        128'h207167A4_2D2B095B_CB9B25D0_BEE56C52,
        128'h59A674D2_E6F4B4C0_D166AFC2_394B63B6
    };

    // Inverse table derived at elaboration so it can never drift from PI.
    function automatic logic [255:0][7:0] invert(input logic [0:255][7:0] t);
        logic [255:0][7:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            r[t[i]] = 8'(i);
        end
        return r;
    endfunction

    localparam logic [255:0][7:0] PI_INV = invert(PI);

    // Byte k holds the l() coefficient of input byte b_k.
    localparam logic [127:0] L_COEF = 128'h94208510_C2C001FB_01C0C210_85209401;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] lmix(input logic [127:0] b);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < 16; k++) begin
            acc = acc ^ gf_mul(b[8*k +: 8], L_COEF[8*k +: 8]);
        end
        return acc;
    endfunction

    function automatic logic [127:0] sinv(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = PI_INV[v[8*k +: 8]];
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        X10,
        LINV,
        SX,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] s_q, s_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   r_q, r_d;
    logic [3:0]   j_q, j_d;

    logic [127:0] linv_v;
    logic [127:0] sx_v;

    // One R^-1 step: shift left a byte, feed l(a14..a0, a15) in at the bottom.
    assign linv_v = {s_q[119:0], lmix({s_q[119:0], s_q[127:120]})};
    assign sx_v   = sinv(s_q) ^ key_i;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        out_d     = out_q;
        r_d       = r_q;
        j_d       = j_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        key_idx_o = 4'd0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    s_d     = in_data;
                    state_d = X10;
                end
            end
            X10: begin
                key_idx_o = 4'(ROUNDS);
                s_d       = s_q ^ key_i;
                r_d       = 4'(ROUNDS - 1);
                j_d       = 4'd0;
                state_d   = LINV;
            end
            LINV: begin
                s_d = linv_v;
                j_d = j_q + 4'd1;
                if (j_q == 4'd15) state_d = SX;
            end
            SX: begin
                key_idx_o = r_q;
                s_d       = sx_v;
                if (r_q > 4'd1) begin
                    r_d     = r_q - 4'd1;
                    j_d     = 4'd0;
                    state_d = LINV;
                end else begin
                    // Result register only moves on DONE entry.
                    out_d   = sx_v;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            out_q   <= '0;
            r_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            out_q   <= out_d;
            r_q     <= r_d;
            j_q     <= j_d;
        end
    end

    assign out_data = out_q;

endmodule
